// File: rtl/wb_pkg.sv
// Shared types and default parameters for the Wishbone classic master.
// The FSM state encoding and default bus/timeout sizes live here.
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wb_state_t;

    localparam int DEF_ADR_WIDTH = 16;
    localparam int DEF_DAT_WIDTH = 16;
    localparam int DEF_TIMEOUT   = 255;
    localparam int TIMER_WIDTH   = 8;

endpackage

// File: rtl/wb_timeout.sv
// Bus-cycle watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the timeout-th enabled cycle is being spent.
module wb_timeout
    import wb_pkg::*;
#(
    parameter int timeout = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TIMER_WIDTH-1:0] LAST_COUNT = TIMER_WIDTH'(timeout - 1);

    logic [TIMER_WIDTH-1:0] count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // The owner leaves the counting state on this cycle, so the counter never wraps.
    assign expired = enable && (count_reg == LAST_COUNT);

endmodule

// File: rtl/wb_master_standard.sv
// Single-outstanding Wishbone classic master bridging a valid/ready command
// port to a valid/ready response port, with a per-transfer ack timeout.
module wb_master_standard
    import wb_pkg::*;
#(
    parameter int adr_width = DEF_ADR_WIDTH,
    parameter int dat_width = DEF_DAT_WIDTH,
    parameter int timeout   = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [adr_width-1:0] req_adr,
    input  logic [dat_width-1:0] req_dat,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [dat_width-1:0] rsp_dat,
    output logic                 rsp_err,
    output logic [adr_width-1:0] wb_adr_o,
    output logic [dat_width-1:0] wb_dat_o,
    output logic                 wb_we_o,
    output logic                 wb_cyc_o,
    output logic                 wb_stb_o,
    input  logic [dat_width-1:0] wb_dat_i,
    input  logic                 wb_ack_i
);

    wb_state_t              state_reg, state_next;
    logic [adr_width-1:0]   adr_reg, adr_next;
    logic [dat_width-1:0]   dat_reg, dat_next;
    logic                   we_reg, we_next;
    logic                   bus_reg, bus_next;
    logic                   rsp_valid_reg, rsp_valid_next;
    logic [dat_width-1:0]   rsp_dat_reg, rsp_dat_next;
    logic                   rsp_err_reg, rsp_err_next;
    logic                   ready_en_reg;
    logic                   accept;
    logic                   expired;

    // ready_en_reg keeps req_ready low until the first edge after reset release.
    assign req_ready = ready_en_reg && (state_reg == ST_IDLE);
    assign accept    = req_valid && req_ready;

    wb_timeout #(
        .timeout (timeout)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .enable  (state_reg == ST_BUS),
        .expired (expired)
    );

    always_comb begin
        state_next     = state_reg;
        adr_next       = adr_reg;
        dat_next       = dat_reg;
        we_next        = we_reg;
        bus_next       = bus_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_dat_next   = rsp_dat_reg;
        rsp_err_next   = rsp_err_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    adr_next   = req_adr;
                    dat_next   = req_we ? req_dat : '0;
                    we_next    = req_we;
                    bus_next   = 1'b1;
                    state_next = ST_BUS;
                end
            end
            ST_BUS: begin
                // Ack has priority over a timeout expiring in the same cycle.
                if (wb_ack_i) begin
                    bus_next       = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = 1'b0;
                    rsp_dat_next   = we_reg ? '0 : wb_dat_i;
                    state_next     = ST_RESP;
                end else if (expired) begin
                    bus_next       = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = 1'b1;
                    rsp_dat_next   = '0;
                    state_next     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = ST_IDLE;
                end
            end
            default: begin
                bus_next       = 1'b0;
                rsp_valid_next = 1'b0;
                state_next     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            adr_reg       <= '0;
            dat_reg       <= '0;
            we_reg        <= 1'b0;
            bus_reg       <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_dat_reg   <= '0;
            rsp_err_reg   <= 1'b0;
            ready_en_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            adr_reg       <= adr_next;
            dat_reg       <= dat_next;
            we_reg        <= we_next;
            bus_reg       <= bus_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_dat_reg   <= rsp_dat_next;
            rsp_err_reg   <= rsp_err_next;
            ready_en_reg  <= 1'b1;
        end
    end

    assign wb_adr_o  = adr_reg;
    assign wb_dat_o  = dat_reg;
    assign wb_we_o   = we_reg;
    assign wb_cyc_o  = bus_reg;
    assign wb_stb_o  = bus_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_dat   = rsp_dat_reg;
    assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_wb_master_standard.sv
// Self-checking bench for wb_master_standard with a behavioural Wishbone slave
// and a memory reference model of the expected responses.
module tb_wb_master_standard;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [15:0] req_adr = '0;
    logic [15:0] req_dat = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_dat;
    logic        rsp_err;
    logic [15:0] wb_adr_o;
    logic [15:0] wb_dat_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [15:0] wb_dat_i;
    logic        wb_ack_i;

    int passed = 0;
    int total  = 0;

    // slave_mode: 0 random wait, 1 fixed wait, 2 never ack, 3 ack held high always
    int slave_mode = 1;
    int fixed_wait = 0;
    int wait_cnt   = 0;
    int rand_wait  = 0;
    logic [15:0] slave_mem [0:255] = '{default: '0};
    logic [15:0] model_mem [0:255] = '{default: '0};

    int   stb_total  = 0;
    int   cyc_rises  = 0;
    int   unstable   = 0;
    logic prev_cyc   = 1'b0;
    logic prev_we    = 1'b0;
    logic [15:0] prev_adr = '0;
    logic [15:0] prev_dat = '0;

    always #5 clk = ~clk;

    wb_master_standard #(
        .adr_width (16),
        .dat_width (16),
        .timeout   (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_adr   (req_adr),
        .req_dat   (req_dat),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_we_o   (wb_we_o),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack_i  (wb_ack_i)
    );

    // Behavioural slave: combinational ack after a number of wait states.
    always_comb begin
        wb_ack_i = 1'b0;
        if (slave_mode == 3)
            wb_ack_i = 1'b1;
        else if (wb_cyc_o && wb_stb_o && slave_mode != 2)
            wb_ack_i = (wait_cnt == ((slave_mode == 1) ? fixed_wait : rand_wait));
    end
    assign wb_dat_i = slave_mem[wb_adr_o[7:0]];

    always @(posedge clk) begin
        if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
            wait_cnt  <= 0;
            rand_wait <= int'($urandom_range(0, 5));
            if (wb_we_o) slave_mem[wb_adr_o[7:0]] <= wb_dat_o;
        end else if (wb_cyc_o && wb_stb_o) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    // Bus monitor: strobe-cycle count, cycle starts, and stability during a transfer.
    always @(posedge clk) begin
        if (wb_stb_o) stb_total <= stb_total + 1;
        if (wb_cyc_o && !prev_cyc) cyc_rises <= cyc_rises + 1;
        if (wb_cyc_o && prev_cyc &&
            (wb_adr_o != prev_adr || wb_dat_o != prev_dat || wb_we_o != prev_we || !wb_stb_o))
            unstable <= unstable + 1;
        prev_cyc <= wb_cyc_o;
        prev_adr <= wb_adr_o;
        prev_dat <= wb_dat_o;
        prev_we  <= wb_we_o;
    end

    // Reference model: a write stores and answers 0, a read returns the stored word,
    // a timed-out transfer answers 0 and leaves memory untouched.
    function automatic logic [15:0] model_rsp(input logic we, input logic [15:0] adr,
                                              input logic [15:0] dat, input bit times_out);
        if (times_out) return 16'h0000;
        if (we) begin
            model_mem[adr[7:0]] = dat;
            return 16'h0000;
        end
        return model_mem[adr[7:0]];
    endfunction

    // Issues one command from a falling edge and collects its response.
    task automatic run_txn(input logic we, input logic [15:0] adr, input logic [15:0] dat,
                           input int hold,
                           output logic [15:0] rdat, output logic err, output int lat,
                           output int stbs, output bit stable_ok, output bit stalled,
                           output logic bus_we, output logic [15:0] bus_dat);
        int n;
        int s0;
        stalled   = 1'b0;
        stable_ok = 1'b1;
        req_valid = 1'b1;
        req_we    = we;
        req_adr   = adr;
        req_dat   = dat;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) stalled = 1'b1;
        s0 = stb_total;
        @(negedge clk);
        req_valid = 1'b0;
        bus_we    = wb_we_o;
        bus_dat   = wb_dat_o;
        lat = 1;
        while (!rsp_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) stalled = 1'b1;
        stbs = stb_total - s0;
        rdat = rsp_dat;
        err  = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_dat !== rdat || rsp_err !== err || req_ready || wb_cyc_o || wb_stb_o)
                stable_ok = 1'b0;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        if (rsp_valid) stable_ok = 1'b0;
        $display("txn we=%0d adr=%h dat=%h -> rsp_dat=%h err=%0d lat=%0d stb=%0d",
                 we, adr, dat, rdat, err, lat, stbs);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (req_ready !== 1'b0) $display("FAIL rst_ready: got %b expected 0", req_ready); else passed++;
        total++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000) $display("FAIL rst_bus: got %b expected 000", {wb_cyc_o, wb_stb_o, wb_we_o}); else passed++;
        total++; if ({wb_adr_o, wb_dat_o} !== 32'h0) $display("FAIL rst_adr_dat: got %h expected 0", {wb_adr_o, wb_dat_o}); else passed++;
        total++; if ({rsp_valid, rsp_err, rsp_dat} !== 18'h0) $display("FAIL rst_rsp: got %h expected 0", {rsp_valid, rsp_err, rsp_dat}); else passed++;
        rst = 1'b1;
        #1;
        total++; if (req_ready !== 1'b0) $display("FAIL rel_ready_pre_edge: got %b expected 0", req_ready); else passed++;
        @(negedge clk);
        total++; if (req_ready !== 1'b1) $display("FAIL rel_ready_post_edge: got %b expected 1", req_ready); else passed++;
    endtask

    task automatic test_write_read;
        logic [15:0] rd, exp, bd;
        logic er, bw;
        int lat, stbs;
        bit st, stl;
        slave_mode = 1;
        fixed_wait = 0;
        exp = model_rsp(1'b1, 16'h0001, 16'h0065, 1'b0);
        run_txn(1'b1, 16'h0001, 16'h0065, 0, rd, er, lat, stbs, st, stl, bw, bd);
        total++; if (stl !== 1'b0) $display("FAIL wr_stall: handshake or response not seen within bound"); else passed++;
        total++; if ({er, rd} !== {1'b0, exp}) $display("FAIL wr_rsp: got err=%b dat=%h expected err=0 dat=%h", er, rd, exp); else passed++;
        total++; if (stbs !== 1) $display("FAIL wr_stb_cycles: got %0d expected 1", stbs); else passed++;
        total++; if (lat !== 2) $display("FAIL wr_latency: got %0d expected 2", lat); else passed++;
        total++; if ({bw, bd} !== {1'b1, 16'h0065}) $display("FAIL wr_bus: got we=%b dat=%h expected we=1 dat=0065", bw, bd); else passed++;
        exp = model_rsp(1'b0, 16'h0001, 16'h0, 1'b0);
        run_txn(1'b0, 16'h0001, 16'hBEEF, 0, rd, er, lat, stbs, st, stl, bw, bd);
        total++; if ({er, rd} !== {1'b0, exp}) $display("FAIL rd_rsp: got err=%b dat=%h expected err=0 dat=%h", er, rd, exp); else passed++;
        total++; if ({bw, bd} !== {1'b0, 16'h0000}) $display("FAIL rd_bus: got we=%b dat=%h expected we=0 dat=0000", bw, bd); else passed++;
        for (int i = 11; i <= 20; i++) begin
            exp = model_rsp(1'b1, 16'(i), 16'(200 + i), 1'b0);
            run_txn(1'b1, 16'(i), 16'(200 + i), 0, rd, er, lat, stbs, st, stl, bw, bd);
        end
        for (int i = 11; i <= 20; i++) begin
            exp = model_rsp(1'b0, 16'(i), 16'h0, 1'b0);
            run_txn(1'b0, 16'(i), 16'h0, 0, rd, er, lat, stbs, st, stl, bw, bd);
            total++; if ({er, rd} !== {1'b0, exp}) $display("FAIL rd_seq adr=%0d: got err=%b dat=%h expected err=0 dat=%h", i, er, rd, exp); else passed++;
        end
    endtask

    task automatic test_random;
        logic [15:0] rd, exp, bd, a, d;
        logic er, bw, w;
        int lat, stbs;
        bit st, stl;
        int u0;
        slave_mode = 0;
        u0 = unstable;
        for (int i = 0; i < 30; i++) begin
            w = 1'($urandom_range(0, 1));
            a = 16'($urandom_range(0, 31));
            d = 16'($urandom);
            exp = model_rsp(w, a, d, 1'b0);
            run_txn(w, a, d, 0, rd, er, lat, stbs, st, stl, bw, bd);
            total++; if ({stl, er, rd} !== {1'b0, 1'b0, exp}) $display("FAIL rand_rsp #%0d: got stall=%b err=%b dat=%h expected stall=0 err=0 dat=%h", i, stl, er, rd, exp); else passed++;
            total++; if (lat !== stbs + 1) $display("FAIL rand_latency #%0d: got %0d expected %0d", i, lat, stbs + 1); else passed++;
        end
        total++; if (unstable - u0 !== 0) $display("FAIL rand_bus_stable: got %0d changes expected 0", unstable - u0); else passed++;
    endtask

    task automatic test_timeout;
        logic [15:0] rd, exp, bd;
        logic er, bw;
        int lat, stbs;
        bit st, stl;
        slave_mode = 2;
        exp = model_rsp(1'b1, 16'h0001, 16'h1234, 1'b1);
        run_txn(1'b1, 16'h0001, 16'h1234, 0, rd, er, lat, stbs, st, stl, bw, bd);
        total++; if ({stl, er, rd} !== {1'b0, 1'b1, exp}) $display("FAIL to_rsp: got stall=%b err=%b dat=%h expected stall=0 err=1 dat=%h", stl, er, rd, exp); else passed++;
        total++; if (stbs !== TO) $display("FAIL to_stb_cycles: got %0d expected %0d", stbs, TO); else passed++;
        slave_mode = 1;
        fixed_wait = TO - 1;
        exp = model_rsp(1'b0, 16'h0001, 16'h0, 1'b0);
        run_txn(1'b0, 16'h0001, 16'h0, 0, rd, er, lat, stbs, st, stl, bw, bd);
        total++; if ({er, rd} !== {1'b0, exp}) $display("FAIL to_ack_wins: got err=%b dat=%h expected err=0 dat=%h", er, rd, exp); else passed++;
        total++; if (stbs !== TO) $display("FAIL to_ack_wins_cycles: got %0d expected %0d", stbs, TO); else passed++;
        fixed_wait = TO - 2;
        exp = model_rsp(1'b0, 16'h0011, 16'h0, 1'b0);
        run_txn(1'b0, 16'h0011, 16'h0, 0, rd, er, lat, stbs, st, stl, bw, bd);
        total++; if ({er, rd, stbs} !== {1'b0, exp, TO - 1}) $display("FAIL to_late_ack: got err=%b dat=%h stb=%0d expected err=0 dat=%h stb=%0d", er, rd, stbs, exp, TO - 1); else passed++;
    endtask

    task automatic test_backpressure;
        logic [15:0] rd, exp, bd;
        logic er, bw;
        int lat, stbs;
        bit st, stl;
        int s0;
        slave_mode = 1;
        fixed_wait = 2;
        exp = model_rsp(1'b0, 16'h0001, 16'h0, 1'b0);
        s0 = cyc_rises;
        run_txn(1'b0, 16'h0001, 16'h0, 5, rd, er, lat, stbs, st, stl, bw, bd);
        total++; if (st !== 1'b1) $display("FAIL bp_stable: got %b expected 1", st); else passed++;
        total++; if ({er, rd} !== {1'b0, exp}) $display("FAIL bp_rsp: got err=%b dat=%h expected err=0 dat=%h", er, rd, exp); else passed++;
        total++; if (cyc_rises - s0 !== 1) $display("FAIL bp_bus_cycles: got %0d expected 1", cyc_rises - s0); else passed++;
    endtask

    task automatic test_ack_idle;
        logic [15:0] rd, exp, bd, d;
        logic er, bw;
        int lat, stbs;
        bit st, stl;
        bit spurious;
        slave_mode = 3;
        spurious = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid || wb_cyc_o || !req_ready) spurious = 1'b1;
        end
        total++; if (spurious !== 1'b0) $display("FAIL idle_ack_ignored: got reaction=%b expected 0", spurious); else passed++;
        d = 16'($urandom);
        exp = model_rsp(1'b1, 16'h0007, d, 1'b0);
        run_txn(1'b1, 16'h0007, d, 3, rd, er, lat, stbs, st, stl, bw, bd);
        total++; if ({st, er, rd, stbs} !== {1'b1, 1'b0, exp, 1}) $display("FAIL resp_ack_ignored: got stable=%b err=%b dat=%h stb=%0d expected 1 0 %h 1", st, er, rd, stbs, exp); else passed++;
        slave_mode = 1;
        fixed_wait = 0;
        exp = model_rsp(1'b0, 16'h0007, 16'h0, 1'b0);
        run_txn(1'b0, 16'h0007, 16'h0, 0, rd, er, lat, stbs, st, stl, bw, bd);
        total++; if ({er, rd} !== {1'b0, exp}) $display("FAIL ack_mode_readback: got err=%b dat=%h expected err=0 dat=%h", er, rd, exp); else passed++;
    endtask

    task automatic test_reset_mid_bus;
        logic [15:0] rd, exp, bd;
        logic er, bw;
        int lat, stbs;
        bit st, stl;
        bit seen;
        slave_mode = 2;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_adr   = 16'h00AB;
        req_dat   = 16'h5A5A;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        total++; if (wb_cyc_o !== 1'b1) $display("FAIL mid_bus_active: got cyc=%b expected 1", wb_cyc_o); else passed++;
        rst = 1'b0;
        #1;
        total++; if ({wb_cyc_o, wb_stb_o, rsp_valid} !== 3'b000) $display("FAIL mid_rst_bus: got %b expected 000", {wb_cyc_o, wb_stb_o, rsp_valid}); else passed++;
        total++; if ({wb_adr_o, wb_dat_o} !== 32'h0) $display("FAIL mid_rst_adr_dat: got %h expected 0", {wb_adr_o, wb_dat_o}); else passed++;
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (TO + 4) begin
            @(negedge clk);
            if (rsp_valid || wb_cyc_o) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) $display("FAIL mid_rst_no_rsp: got activity=%b expected 0", seen); else passed++;
        slave_mode = 1;
        fixed_wait = 1;
        exp = model_rsp(1'b0, 16'h0001, 16'h0, 1'b0);
        run_txn(1'b0, 16'h0001, 16'h0, 0, rd, er, lat, stbs, st, stl, bw, bd);
        total++; if ({stl, er, rd, lat} !== {1'b0, 1'b0, exp, 32'd3}) $display("FAIL post_rst_read: got stall=%b err=%b dat=%h lat=%0d expected 0 0 %h 3", stl, er, rd, lat, exp); else passed++;
    endtask

    task automatic test_back_to_back;
        localparam int N = 12;
        logic        cw [N];
        logic [15:0] ca [N];
        logic [15:0] cd [N];
        logic [15:0] exp_q [$];
        logic [15:0] exp;
        int idx, got, r0;
        bit hs_req, hs_rsp;
        for (int i = 0; i < N; i++) begin
            cw[i] = 1'($urandom_range(0, 1));
            ca[i] = 16'($urandom_range(0, 15));
            cd[i] = 16'($urandom);
        end
        slave_mode = 0;
        r0 = cyc_rises;
        idx = 0;
        got = 0;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_we = cw[0];
        req_adr = ca[0];
        req_dat = cd[0];
        for (int c = 0; c < 2000 && got < N; c++) begin
            hs_req = req_valid && req_ready;
            hs_rsp = rsp_valid;
            if (hs_rsp) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                $display("txn b2b #%0d -> rsp_dat=%h err=%0d", got, rsp_dat, rsp_err);
                total++; if ({rsp_err, rsp_dat} !== {1'b0, exp}) $display("FAIL b2b_rsp #%0d: got err=%b dat=%h expected err=0 dat=%h", got, rsp_err, rsp_dat, exp); else passed++;
                got++;
            end
            if (hs_req) begin
                exp_q.push_back(model_rsp(cw[idx], ca[idx], cd[idx], 1'b0));
                idx++;
            end
            @(posedge clk);
            #1;
            if (hs_req) begin
                if (idx < N) begin
                    req_we = cw[idx];
                    req_adr = ca[idx];
                    req_dat = cd[idx];
                end else begin
                    req_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        total++; if (got !== N) $display("FAIL b2b_count: got %0d responses expected %0d", got, N); else passed++;
        total++; if (cyc_rises - r0 !== N) $display("FAIL b2b_cyc_gaps: got %0d separate bus cycles expected %0d", cyc_rises - r0, N); else passed++;
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_random;
        test_timeout;
        test_backpressure;
        test_ack_idle;
        test_reset_mid_bus;
        test_back_to_back;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
